// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle RV32I/RV32E core on one shared req/ready memory port
// Ports: clk; rst (asynchronous, active-low); mem_req/mem_we/mem_addr/mem_wdata to memory;
//        mem_rdata/mem_ready from memory; halted (stopped on a trap); pc_o (debug PC).
// Option: MULTICYCLE_CPU_RETIRE_EN adds retire (pulse per completed instruction) and
//         instret (64-bit retirement counter).
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
`ifdef MULTICYCLE_CPU_RETIRE_EN
    output logic        retire,
    output logic [63:0] instret,
`endif
    output logic        halted,
    output logic [31:0] pc_o
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
    localparam logic [5:0] NR = 6'(NREGS);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, tgt_q, tgt_d, mdr_q, mdr_d;
    logic        live_q, wr_en;
    logic [31:0] regs_q [32];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    logic        legal, bad_reg, misalign, trap, taken;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, op2, sra, alu_r, jtgt, maddr, result, pc4;

    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    assign is_lui   = opc == 7'b0110111;
    assign is_auipc = opc == 7'b0010111;
    assign is_jal   = opc == 7'b1101111;
    assign is_jalr  = opc == 7'b1100111;
    assign is_br    = opc == 7'b1100011;
    assign is_ld    = opc == 7'b0000011;
    assign is_st    = opc == 7'b0100011;
    assign is_opi   = opc == 7'b0010011;
    assign is_op    = opc == 7'b0110011;

    // Shift immediates carry a funct7 that must be 0 (or 0x20 for SRAI); branches lack f3 2/3.
    assign legal = is_lui | is_auipc | is_jal | (is_jalr & (f3 == 3'b000)) |
                   (is_br & (f3[2:1] != 2'b01)) | ((is_ld | is_st) & (f3 == 3'b010)) |
                   (is_opi & (f3 == 3'b001 ? f7 == 7'h00 :
                              f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1)) |
                   (is_op & (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))));

    // Only register fields that the format actually uses are range-checked.
    assign bad_reg = ((is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op) && ({1'b0, rd} >= NR)) ||
                     ((is_jalr | is_br | is_ld | is_st | is_opi | is_op) && ({1'b0, rs1} >= NR)) ||
                     ((is_br | is_st | is_op) && ({1'b0, rs2} >= NR));

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign op2   = is_op ? b_q : imm_i;
    assign shamt = op2[4:0];
    assign sra   = $signed(a_q) >>> shamt;
    assign alu_r = f3 == 3'b000 ? ((is_op & ir_q[30]) ? a_q - op2 : a_q + op2) :
                   f3 == 3'b001 ? a_q << shamt :
                   f3 == 3'b010 ? {31'b0, $signed(a_q) < $signed(op2)} :
                   f3 == 3'b011 ? {31'b0, a_q < op2} :
                   f3 == 3'b100 ? a_q ^ op2 :
                   f3 == 3'b101 ? (ir_q[30] ? sra : a_q >> shamt) :
                   f3 == 3'b110 ? a_q | op2 : a_q & op2;

    // f3[0] inverts the base condition: BNE/BGE/BGEU from BEQ/BLT/BLTU.
    assign taken = f3[2] ? ((f3[1] ? a_q < b_q : $signed(a_q) < $signed(b_q)) ^ f3[0])
                         : ((a_q == b_q) ^ f3[0]);

    assign pc4      = pc_q + 32'd4;
    assign jtgt     = is_jal ? pc_q + imm_j : is_jalr ? (a_q + imm_i) & ~32'd1 : pc_q + imm_b;
    assign maddr    = a_q + (is_st ? imm_s : imm_i);
    assign misalign = ((is_ld | is_st) & (maddr[1:0] != 2'b00)) |
                      ((is_jal | is_jalr | (is_br & taken)) & (jtgt[1:0] != 2'b00));
    assign trap     = !legal | bad_reg | misalign;
    assign result   = is_lui ? imm_u : is_auipc ? pc_q + imm_u :
                      (is_jal | is_jalr) ? pc4 : (is_ld | is_st) ? maddr : alu_r;

    // live_q keeps the bus idle (all zero) until the first edge after reset release.
    assign mem_req   = live_q && (state_q == FETCH || state_q == MEM);
    assign mem_we    = mem_req && state_q == MEM && is_st;
    assign mem_addr  = !mem_req ? 32'd0 : state_q == MEM ? alu_q : pc_q;
    assign mem_wdata = mem_we ? b_q : 32'd0;
    assign halted    = state_q == HALT;
    assign pc_o      = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        tgt_d   = tgt_q;
        mdr_d   = mdr_q;
        wr_en   = 1'b0;
        case (state_q)
            FETCH: if (mem_req && mem_ready) begin
                ir_d    = mem_rdata;
                state_d = DECODE;
            end
            DECODE: begin
                a_d     = regs_q[rs1];
                b_d     = regs_q[rs2];
                state_d = EXEC;
            end
            EXEC: if (trap) state_d = HALT;
            else if (is_br) begin
                pc_d    = taken ? jtgt : pc4;
                state_d = FETCH;
            end else begin
                alu_d   = result;
                tgt_d   = jtgt;
                state_d = (is_ld | is_st) ? MEM : WB;
            end
            MEM: if (mem_ready) begin
                mdr_d   = mem_rdata;
                pc_d    = is_st ? pc4 : pc_q;
                state_d = is_st ? FETCH : WB;
            end
            WB: begin
                wr_en   = rd != 5'd0;
                pc_d    = (is_jal | is_jalr) ? tgt_q : pc4;
                state_d = FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            tgt_q   <= '0;
            mdr_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            tgt_q   <= tgt_d;
            mdr_q   <= mdr_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        else if (wr_en) regs_q[rd] <= is_ld ? mdr_q : alu_q;
    end

`ifdef MULTICYCLE_CPU_RETIRE_EN
    logic [63:0] instret_q;
    assign retire  = state_q == WB || (state_q == EXEC && is_br && !trap) ||
                     (state_q == MEM && is_st && mem_ready);
    assign instret = instret_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instret_q <= '0;
        else if (retire) instret_q <= instret_q + 64'd1;
    end
`endif
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed self-checking bench for multicycle_cpu
module tb_multicycle_cpu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, sel = 1'b0, stall = 1'b0;
    int ws = 0, wcnt = 0, cyc = 0, nwr = 0, checks = 0, errors = 0;
    logic [31:0] mem [256];
    logic [31:0] waddr = '0, wdat = '0;
    logic req_a, we_a, halt_a, req_b, we_b, halt_b;
    logic [31:0] addr_a, wdata_a, pc_a, addr_b, wdata_b, pc_b;
    logic req, we, halted, mem_ready;
    logic [31:0] addr, wdata, pc, mem_rdata;
`ifdef MULTICYCLE_CPU_RETIRE_EN
    logic ret_a, ret_b;
    logic [63:0] cnt_a, cnt_b;
`endif

    assign req       = sel ? req_b : req_a;
    assign we        = sel ? we_b : we_a;
    assign addr      = sel ? addr_b : addr_a;
    assign wdata     = sel ? wdata_b : wdata_a;
    assign halted    = sel ? halt_b : halt_a;
    assign pc        = sel ? pc_b : pc_a;
    assign mem_ready = req && !(stall && addr == 32'h8) && wcnt == ws;
    assign mem_rdata = mem[addr[9:2]];

    always @(posedge clk) begin
        cyc++;
        if (req && we && mem_ready) begin
            mem[addr[9:2]] = wdata;
            waddr = addr;
            wdat = wdata;
            nwr++;
        end
        wcnt <= (!req || mem_ready) ? 0 : wcnt + 1;
    end

    multicycle_cpu #(.RESET_PC(32'h100), .NREGS(32)) dut_a (
        .clk(clk), .rst(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef MULTICYCLE_CPU_RETIRE_EN
        .retire(ret_a), .instret(cnt_a),
`endif
        .halted(halt_a), .pc_o(pc_a));

    multicycle_cpu #(.RESET_PC(32'h100), .NREGS(16)) dut_b (
        .clk(clk), .rst(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef MULTICYCLE_CPU_RETIRE_EN
        .retire(ret_b), .instret(cnt_b),
`endif
        .halted(halt_b), .pc_o(pc_b));

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [20:0] v;
        v = 21'(imm);
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction
    function automatic logic [31:0] rd_reg(int i);
        return sel ? dut_b.regs_q[i] : dut_a.regs_q[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[9:2]] = w;
    endtask

    task automatic hold();
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        ws = 0;
        stall = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic go(input logic b);
        sel = b;
        @(negedge clk);
        if (b) rst_b = 1'b1;
        else rst_a = 1'b1;
    endtask

    task automatic wait_fetch(input logic [31:0] a, output int t);
        int n = 0;
        while (!(req && !we && addr == a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("fetch_%h_seen", a), 32'(n < 200), 32'd1);
        t = cyc;
    endtask

    task automatic wait_halt(output int t);
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("halt_seen", 32'(n < 300), 32'd1);
        t = cyc;
    endtask

    task automatic trap_case(input string tag, input logic b, input logic [31:0] ins, input int rd);
        int n0, t;
        hold();
        put(32'h100, enc_i(6, 0, 0, 1, 7'h13));
        put(32'h104, ins);
        n0 = nwr;
        go(b);
        wait_halt(t);
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_x1"}, rd_reg(1), 32'd6);
        chk({tag, "_rd"}, rd_reg(rd), 32'd0);
        chk({tag, "_nowrite"}, 32'(nwr - n0), 32'd0);
        chk({tag, "_pc"}, pc, 32'h104);
    endtask

    initial begin
        int t0, t1, t2, t3, n0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        put(32'h100, enc_i(-5, 0, 0, 1, 7'h13));
        put(32'h104, enc_i(3, 0, 0, 2, 7'h13));
        put(32'h108, enc_r(0, 2, 1, 2, 3));
        put(32'h10C, enc_r(0, 2, 1, 3, 4));
        put(32'h110, enc_i(32'h401, 1, 5, 5, 7'h13));
        put(32'h114, enc_r(0, 2, 1, 0, 0));
        put(32'h118, enc_i(32'h21, 0, 0, 9, 7'h13));
        put(32'h11C, enc_b(8, 2, 1, 1));
        put(32'h120, enc_i(1, 0, 0, 8, 7'h13));
        put(32'h124, enc_i(16, 0, 0, 10, 7'h67));
        put(32'h010, enc_j(-4, 7));
        put(32'h00C, enc_i(0, 9, 0, 11, 7'h67));
        put(32'h020, {20'h12345, 5'd12, 7'h37});
        put(32'h024, {20'h00001, 5'd13, 7'h17});
        put(32'h028, 32'h0000_007F);
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", pc, 32'h100);
        rst_a = 1'b1;
        t0 = cyc;
        wait_fetch(32'h100, t1);
        chk("first_fetch_latency", 32'(t1 - t0), 32'd1);
        chk("first_fetch_we", 32'(we), 32'd0);
        chk("first_fetch_halted", 32'(halted), 32'd0);
        wait_fetch(32'h104, t2);
        chk("addi_cycles", 32'(t2 - t1), 32'd4);
        wait_fetch(32'h108, t1);
        wait_fetch(32'h10C, t2);
        chk("slt_cycles", 32'(t2 - t1), 32'd4);
        wait_fetch(32'h114, t1);
        wait_fetch(32'h118, t2);
        chk("add_x0_cycles", 32'(t2 - t1), 32'd4);
        wait_fetch(32'h11C, t1);
        wait_fetch(32'h124, t2);
        chk("bne_taken_cycles", 32'(t2 - t1), 32'd3);
        wait_fetch(32'h010, t1);
        chk("jalr_cycles", 32'(t1 - t2), 32'd4);
        wait_fetch(32'h00C, t1);
        wait_fetch(32'h020, t1);
        wait_fetch(32'h028, t1);
        wait_halt(t2);
        chk("halt_latency", 32'(t2 - t1), 32'd3);
        chk("x1", rd_reg(1), 32'hFFFF_FFFB);
        chk("x2", rd_reg(2), 32'd3);
        chk("x3_slt", rd_reg(3), 32'd1);
        chk("x4_sltu", rd_reg(4), 32'd0);
        chk("x5_srai", rd_reg(5), 32'hFFFF_FFFD);
        chk("x0_zero", rd_reg(0), 32'd0);
        chk("x8_skipped", rd_reg(8), 32'd0);
        chk("x10_jalr_link", rd_reg(10), 32'h128);
        chk("x7_jal_link", rd_reg(7), 32'h14);
        chk("x11_jalr_link", rd_reg(11), 32'h10);
        chk("x12_lui", rd_reg(12), 32'h1234_5000);
        chk("x13_auipc", rd_reg(13), 32'h0000_1024);
        chk("halt_pc", pc, 32'h028);

        hold();
        ws = 2;
        put(32'h100, enc_i(-5, 0, 0, 1, 7'h13));
        put(32'h104, enc_s(8, 1, 0, 2));
        put(32'h108, enc_i(8, 0, 2, 6, 7'h03));
        put(32'h10C, 32'h0000_007F);
        n0 = nwr;
        go(1'b0);
        wait_fetch(32'h104, t1);
        wait_fetch(32'h108, t2);
        chk("sw_ws2_cycles", 32'(t2 - t1), 32'd8);
        wait_fetch(32'h10C, t3);
        chk("lw_ws2_cycles", 32'(t3 - t2), 32'd9);
        wait_halt(t1);
        chk("sw_count", 32'(nwr - n0), 32'd1);
        chk("sw_addr", waddr, 32'h8);
        chk("sw_data", wdat, 32'hFFFF_FFFB);
        chk("x6_lw", rd_reg(6), 32'hFFFF_FFFB);

        trap_case("trap_lw_misaligned", 1'b0, enc_i(0, 1, 2, 2, 7'h03), 2);
        trap_case("trap_lb", 1'b0, enc_i(0, 0, 0, 2, 7'h03), 2);
        trap_case("trap_sb", 1'b0, enc_s(0, 1, 0, 0), 2);
        trap_case("trap_op7f", 1'b0, {25'd0 | (32'd2 << 7), 7'h7F}, 2);
        trap_case("trap_rv32e_x17", 1'b1, enc_r(0, 1, 1, 0, 17), 17);

        hold();
        stall = 1'b1;
        put(32'h100, enc_i(-5, 0, 0, 1, 7'h13));
        put(32'h104, enc_i(8, 0, 2, 6, 7'h03));
        put(32'h008, 32'h55);
        go(1'b0);
        wait_fetch(32'h8, t1);
        repeat (2) @(negedge clk);
        chk("stall_req_held", 32'(req), 32'd1);
        chk("stall_addr_held", addr, 32'h8);
        chk("stall_x1", rd_reg(1), 32'hFFFF_FFFB);
        rst_a = 1'b0;
        #1;
        chk("async_rst_req", 32'(req), 32'd0);
        chk("async_rst_addr", addr, 32'd0);
        chk("async_rst_x1", rd_reg(1), 32'd0);
        chk("async_rst_x6", rd_reg(6), 32'd0);
        @(negedge clk);
        stall = 1'b0;
        rst_a = 1'b1;
        t0 = cyc;
        wait_fetch(32'h100, t1);
        chk("refetch_latency", 32'(t1 - t0), 32'd1);
        chk("refetch_pc", pc, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
